mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
- Multi-cycle shift-add sequencer for the `mul` instruction (funct 6'b011000).
- The instruction controller pulses `start` when `mul` reaches execute. This block holds the pipeline with `stall` while it iterates.
- It then returns the low WIDTH bits of the product, plus the destination register, for writeback.
- The single-cycle ALU is not used for `mul`; this block owns that operation end to end.

Parameters:
- WIDTH, 32, operand/result width and iteration count.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLOCK  input  1  system clock; all state updates on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request from controller; `mul` is decoded in execute.
- op_a  input  WIDTH  rs operand (multiplicand), sampled only when start is accepted.
- op_b  input  WIDTH  rt operand (multiplier), sampled only when start is accepted.
- dest_in  input  5  rd field of the `mul`, sampled only when start is accepted.
- flush  input  1  squash the in-flight operation (branch/jump redirect).
- stall  output  1  freeze PC and pipeline registers upstream of execute.
- busy  output  1  high in RUN.
- result_valid  output  1  one-cycle pulse; result and result_reg are valid.
- result  output  WIDTH  low WIDTH bits of op_a*op_b.
- result_reg  output  5  writeback register number.

Behaviour:
- Clock/reset: one clock, CLOCK. RESET is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - Counter, accumulator, operand registers, result, result_reg all 0.
  - result_valid=0, busy=0.
  - stall=0 (unless start is high in that same cycle and RESET=0).
- Reset wins over every other input in the same cycle. Reset mid-RUN aborts with no result_valid.
- States: IDLE, RUN, DONE (encoding from shared package).
- Start acceptance:
  - start is accepted in IDLE or DONE when flush=0.
  - On accept, latch mcand=op_a, mplier=op_b, dest=dest_in; acc=0, count=0; next state RUN.
- RUN, each cycle:
  - If mplier[0], acc <= acc + mcand, modulo 2^WIDTH (carry discarded).
  - mcand <= mcand<<1; mplier <= mplier>>1; count <= count+1.
  - When count == WIDTH-1, go to DONE (exactly WIDTH RUN cycles; no early termination).
- DONE (one cycle):
  - result_valid=1; result=acc and result_reg=dest, registered.
  - result and result_reg hold their values until the next DONE or RESET.
  - Next state is IDLE, or RUN if a start is accepted in this cycle.
- stall is combinational: stall = (state==RUN) | (start & ~flush & (state==IDLE | state==DONE)).
- Timing: start accepted at cycle 0 → stall high cycles 0..WIDTH → result_valid at cycle WIDTH+1, where stall is low unless a new start arrives.
- Arithmetic: result equals the low WIDTH bits of the product. This is identical for signed and unsigned operands; no sign handling is needed.
- start while in RUN: ignored; operand registers are unchanged. The controller must not issue it, because stall is high.
- flush:
  - In RUN: return to IDLE next cycle; no result_valid; stall drops the next cycle.
  - In IDLE/DONE together with start: flush wins; the start is dropped.
  - flush in DONE does not suppress the already-registered result_valid pulse.
- result_reg==0: the result is still produced. Suppressing the $zero write is the register file's job.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE/RUN/DONE, 2 bits).
  - FUNCT_MUL=6'b011000.
  - Register-number width (5).
- The controller references FUNCT_MUL to generate `start`.
- One natural sub-module, mul_datapath: mcand/mplier/acc registers plus the add/shift step, controlled by load/step enables.
- FSM, counter and handshake stay in mul_sequencer.

Test Plan (WIDTH=32):
- Basic: op_a=3, op_b=5, dest_in=9, start at cycle 0 → stall high cycles 0–32; result_valid only at cycle 33 with result=15, result_reg=9; stall=0 at 33.
- Wrap: op_a=op_b=32'hFFFFFFFF → result=32'h00000001. Signed case op_a=32'hFFFFFFF9 (-7), op_b=6 → result=32'hFFFFFFD6 (-42).
- Flush:
  - start at cycle 0, flush at cycle 10 → state IDLE at 11, stall=0 at 11, no result_valid through cycle 40.
  - start+flush together in IDLE → stall=0, busy never rises.
- Back-to-back: start (2×4, dest 3) at cycle 0; start (7×8, dest 4) at cycle 33 (DONE) → result_valid at 33 (8, reg 3) and at 66 (56, reg 4); stall high continuously 0–65.
- Ignored start / reset: extra start pulses at cycles 5 and 20 of an operation → the single result is unchanged. RESET at cycle 15 of RUN → at 16: IDLE, stall=0, busy=0, result=0, no result_valid afterwards.

Source files
------------

// File: rtl/mul_sequencer_pkg.sv
// mul_sequencer_pkg
//   Shared definitions for the multi-cycle `mul` sequencer and the
//   instruction controller that issues it.
//   Contents:
//     state_t    FSM encoding (IDLE / RUN / DONE, 2 bits)
//     FUNCT_MUL  funct field of the `mul` instruction; the controller
//                decodes it to generate the sequencer's start pulse
//     REG_W      register-number width (rd field)
package mul_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [5:0] FUNCT_MUL = 6'b011000;

    localparam int REG_W = 5;

endpackage

// File: rtl/mul_datapath.sv
// mul_datapath
//   Shift-add multiplier datapath: holds the multiplicand, multiplier and
//   accumulator, and performs one add/shift step per enabled cycle.
//   Ports:
//     CLOCK        in   system clock, rising edge
//     RESET        in   synchronous active-high reset, clears all registers
//     i_load       in   load operands and clear accumulator
//     i_step       in   perform one add/shift iteration
//     i_op_a       in   multiplicand loaded on i_load
//     i_op_b       in   multiplier loaded on i_load
//     o_acc_next   out  accumulator value after the current iteration
module mul_datapath
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic [WIDTH-1:0] o_acc_next
);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_accNext;

    // The addend is the shifted multiplicand whenever the current low
    // multiplier bit is set. The sum is truncated to WIDTH bits, which is
    // exactly the low half of the product for both signed and unsigned
    // operands. The next-accumulator value is exported so the sequencer
    // can capture the final sum on the same edge as the last step.
    always_comb begin
        w_addend  = r_mplier[0] ? r_mcand : '0;
        w_accNext = r_acc + w_addend;
    end

    assign o_acc_next = w_accNext;

    // Operand and accumulator registers. A load takes priority over a step
    // so a new operation can start in the same cycle the previous one ends.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_load) begin
            r_mcand  <= i_op_a;
            r_mplier <= i_op_b;
            r_acc    <= '0;
        end else if (i_step) begin
            r_acc    <= w_accNext;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer
//   Multi-cycle shift-add sequencer for the `mul` instruction. Accepts a
//   start pulse from the controller, stalls the pipeline for WIDTH
//   iterations and then presents the low WIDTH bits of the product with
//   its destination register for one cycle.
//   Ports:
//     CLOCK           in   system clock, rising edge
//     RESET           in   synchronous active-high reset
//     i_start         in   one-cycle request from the controller
//     i_op_a          in   multiplicand (rs), sampled on accepted start
//     i_op_b          in   multiplier (rt), sampled on accepted start
//     i_dest_in       in   rd field, sampled on accepted start
//     i_flush         in   squash the in-flight operation
//     o_stall         out  freeze upstream pipeline (combinational)
//     o_busy          out  high while iterating
//     o_result_valid  out  one-cycle pulse, result/result_reg valid
//     o_result        out  low WIDTH bits of op_a*op_b
//     o_result_reg    out  writeback register number
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic [REG_W-1:0] i_dest_in,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_busy,
    output logic             o_result_valid,
    output logic [WIDTH-1:0] o_result,
    output logic [REG_W-1:0] o_result_reg
);

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_count;
    logic [REG_W-1:0] r_dest;
    logic [WIDTH-1:0] r_result;
    logic [REG_W-1:0] r_resultReg;
    logic             r_resultValid;
    logic             w_accept;
    logic             w_step;
    logic             w_lastIter;
    logic             w_finish;
    logic [WIDTH-1:0] w_accNext;

    mul_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .i_load     (w_accept),
        .i_step     (w_step),
        .i_op_a     (i_op_a),
        .i_op_b     (i_op_b),
        .o_acc_next (w_accNext)
    );

    // Handshake decode and next-state logic. A start is only honoured
    // when no operation is iterating, and a flush always beats it. The
    // last iteration is the one where the counter reads WIDTH-1, giving
    // exactly WIDTH RUN cycles. A flush during RUN abandons the operation
    // without stepping or finishing.
    always_comb begin
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_lastIter  = (r_count == CNT_W'(WIDTH - 1));
        w_finish    = 1'b0;
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                w_accept = i_start & ~i_flush;
                if (w_accept) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_flush) begin
                    w_nextState = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (w_lastIter) begin
                        w_finish    = 1'b1;
                        w_nextState = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_accept    = i_start & ~i_flush;
                w_nextState = w_accept ? ST_RUN : ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // State, counter and result registers. The result is captured from the
    // datapath's next-accumulator value on the edge that ends the final
    // iteration, so it appears together with the valid pulse in DONE and
    // then holds until the next completed operation or a reset.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_dest        <= '0;
            r_result      <= '0;
            r_resultReg   <= '0;
            r_resultValid <= 1'b0;
        end else begin
            r_state       <= w_nextState;
            r_resultValid <= w_finish;
            if (w_accept) begin
                r_count <= '0;
                r_dest  <= i_dest_in;
            end else if (w_step) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (w_finish) begin
                r_result    <= w_accNext;
                r_resultReg <= r_dest;
            end
        end
    end

    // Stall covers both the accepting cycle and every iteration, so the
    // instruction after `mul` is held from the moment it is issued.
    assign o_stall        = (r_state == ST_RUN) | w_accept;
    assign o_busy         = (r_state == ST_RUN);
    assign o_result_valid = r_resultValid;
    assign o_result       = r_result;
    assign o_result_reg   = r_resultReg;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer
//   Self-checking bench for mul_sequencer (WIDTH=32). Expected products are
//   pushed to a scoreboard when a start is driven and compared when the
//   design raises result_valid; cycle timing of stall/busy/valid is checked
//   against each operation's start cycle.
module tb_mul_sequencer;
    import mul_sequencer_pkg::*;

    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [REG_W-1:0] rg;
    } expect_t;

    logic             CLOCK = 1'b0;
    logic             RESET;
    logic             i_start;
    logic [WIDTH-1:0] i_op_a;
    logic [WIDTH-1:0] i_op_b;
    logic [REG_W-1:0] i_dest_in;
    logic             i_flush;
    logic             o_stall;
    logic             o_busy;
    logic             o_result_valid;
    logic [WIDTH-1:0] o_result;
    logic [REG_W-1:0] o_result_reg;

    expect_t expQ[$];
    int      validQ[$];
    int      cyc = 0;
    int      checkCount = 0;
    int      passCount = 0;

    mul_sequencer #(
        .WIDTH (WIDTH),
        .CNT_W (6)
    ) dut (
        .CLOCK          (CLOCK),
        .RESET          (RESET),
        .i_start        (i_start),
        .i_op_a         (i_op_a),
        .i_op_b         (i_op_b),
        .i_dest_in      (i_dest_in),
        .i_flush        (i_flush),
        .o_stall        (o_stall),
        .o_busy         (o_busy),
        .o_result_valid (o_result_valid),
        .o_result       (o_result),
        .o_result_reg   (o_result_reg)
    );

    // 10 ns clock period.
    always #5 CLOCK = ~CLOCK;

    // Free-running cycle number used to time-stamp result_valid pulses.
    always @(posedge CLOCK) cyc <= cyc + 1;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard consumer: every valid pulse must match the oldest pending
    // expectation; a pulse with nothing pending is itself a failure.
    always @(negedge CLOCK) begin
        if (o_result_valid === 1'b1) begin
            validQ.push_back(cyc);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_valid", 32'd1, 32'd0);
            end else begin
                expect_t e;
                e = expQ.pop_front();
                checkOutput("result", o_result, e.res);
                checkOutput("result_reg", WIDTH'(o_result_reg), WIDTH'(e.rg));
            end
        end
    end

    // Drive a start for the current cycle; optionally record the expected
    // low-word product for the scoreboard.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [REG_W-1:0] d, input bit expectResult);
        expect_t e;
        logic [WIDTH-1:0] prod;
        i_start   = 1'b1;
        i_op_a    = a;
        i_op_b    = b;
        i_dest_in = d;
        prod      = a * b;
        e.res     = prod;
        e.rg      = d;
        if (expectResult) expQ.push_back(e);
    endtask

    // Sample the current cycle mid-period, then advance to just after the
    // next rising edge where the following cycle's inputs are driven.
    task automatic stepCycle(output logic s, output logic bz,
                             output logic [WIDTH-1:0] r, output logic [REG_W-1:0] rr);
        @(negedge CLOCK);
        s  = o_stall;
        bz = o_busy;
        r  = o_result;
        rr = o_result_reg;
        @(posedge CLOCK);
        #1;
    endtask

    // Isolated operation: start at cycle 0, valid expected at cycle 33.
    task automatic runPlain(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [REG_W-1:0] d, input string tag);
        logic s, bz;
        logic [WIDTH-1:0] r;
        logic [REG_W-1:0] rr;
        int base;
        validQ.delete();
        applyStimulus(a, b, d, 1'b1);
        base = cyc;
        for (int c = 0; c < 36; c++) begin
            stepCycle(s, bz, r, rr);
            if (c == 0) i_start = 1'b0;
        end
        checkOutput({tag, "_vcount"}, WIDTH'(validQ.size()), 32'd1);
        if (validQ.size() > 0) checkOutput({tag, "_vcyc"}, WIDTH'(validQ[0] - base), 32'd33);
    endtask

    initial begin
        logic s, bz;
        logic [WIDTH-1:0] r;
        logic [REG_W-1:0] rr;
        int base, stallErr, busyErr;

        RESET = 1'b1; i_start = 1'b0; i_flush = 1'b0;
        i_op_a = '0; i_op_b = '0; i_dest_in = '0;
        repeat (2) @(posedge CLOCK);
        #1;
        checkOutput("rst_stall", WIDTH'(o_stall), 32'd0);
        checkOutput("rst_busy", WIDTH'(o_busy), 32'd0);
        checkOutput("rst_valid", WIDTH'(o_result_valid), 32'd0);
        checkOutput("rst_result", o_result, 32'd0);
        checkOutput("rst_result_reg", WIDTH'(o_result_reg), 32'd0);
        RESET = 1'b0;
        stepCycle(s, bz, r, rr);

        // Basic 3*5 -> r9 with full stall/busy timing.
        $display("[TB] basic");
        validQ.delete();
        applyStimulus(32'd3, 32'd5, 5'd9, 1'b1);
        base = cyc; stallErr = 0; busyErr = 0;
        for (int c = 0; c < 36; c++) begin
            stepCycle(s, bz, r, rr);
            if (c == 0) i_start = 1'b0;
            if (s !== (c <= 32)) stallErr++;
            if (bz !== (c >= 1 && c <= 32)) busyErr++;
        end
        checkOutput("basic_stall", WIDTH'(stallErr), 32'd0);
        checkOutput("basic_busy", WIDTH'(busyErr), 32'd0);
        checkOutput("basic_vcount", WIDTH'(validQ.size()), 32'd1);
        if (validQ.size() > 0) checkOutput("basic_vcyc", WIDTH'(validQ[0] - base), 32'd33);
        checkOutput("hold_result", r, 32'd15);
        checkOutput("hold_result_reg", WIDTH'(rr), 32'd9);

        // Wrap-around, signed, r0 and random operands.
        runPlain(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, "wrap");
        runPlain(32'hFFFFFFF9, 32'd6, 5'd2, "signed");
        runPlain(32'd12, 32'd13, 5'd0, "zero_rd");
        runPlain(32'h80000000, 32'd3, 5'd31, "msb");
        for (int k = 0; k < 3; k++) begin
            runPlain($urandom, $urandom, 5'($urandom_range(0, 31)), "rand");
        end

        // Flush at cycle 10 of RUN.
        $display("[TB] flush in run");
        validQ.delete();
        applyStimulus(32'd11, 32'd17, 5'd6, 1'b0);
        for (int c = 0; c <= 40; c++) begin
            if (c == 10) i_flush = 1'b1;
            if (c == 11) i_flush = 1'b0;
            stepCycle(s, bz, r, rr);
            if (c == 0) i_start = 1'b0;
            if (c == 11) begin
                checkOutput("flush_stall", WIDTH'(s), 32'd0);
                checkOutput("flush_busy", WIDTH'(bz), 32'd0);
            end
        end
        checkOutput("flush_novalid", WIDTH'(validQ.size()), 32'd0);

        // Start together with flush in IDLE is dropped.
        $display("[TB] start+flush in idle");
        applyStimulus(32'd5, 32'd5, 5'd5, 1'b0);
        i_flush = 1'b1;
        stepCycle(s, bz, r, rr);
        checkOutput("sf_stall", WIDTH'(s), 32'd0);
        i_start = 1'b0; i_flush = 1'b0;
        busyErr = 0;
        for (int c = 0; c < 5; c++) begin
            stepCycle(s, bz, r, rr);
            if (bz !== 1'b0) busyErr++;
        end
        checkOutput("sf_busy", WIDTH'(busyErr), 32'd0);

        // Back-to-back: second start issued in DONE.
        $display("[TB] back-to-back");
        validQ.delete();
        applyStimulus(32'd2, 32'd4, 5'd3, 1'b1);
        base = cyc; stallErr = 0;
        for (int c = 0; c < 70; c++) begin
            if (c == 33) applyStimulus(32'd7, 32'd8, 5'd4, 1'b1);
            stepCycle(s, bz, r, rr);
            if (c == 0 || c == 33) i_start = 1'b0;
            if (s !== (c <= 65)) stallErr++;
        end
        checkOutput("b2b_stall", WIDTH'(stallErr), 32'd0);
        checkOutput("b2b_vcount", WIDTH'(validQ.size()), 32'd2);
        if (validQ.size() > 1) begin
            checkOutput("b2b_vcyc0", WIDTH'(validQ[0] - base), 32'd33);
            checkOutput("b2b_vcyc1", WIDTH'(validQ[1] - base), 32'd66);
        end

        // Start pulses during RUN are ignored.
        $display("[TB] ignored start");
        validQ.delete();
        applyStimulus(32'd6, 32'd7, 5'd5, 1'b1);
        base = cyc;
        for (int c = 0; c < 36; c++) begin
            if (c == 5 || c == 20) begin
                i_start = 1'b1; i_op_a = 32'd100; i_op_b = 32'd100; i_dest_in = 5'd1;
            end
            stepCycle(s, bz, r, rr);
            i_start = 1'b0;
        end
        checkOutput("ign_vcount", WIDTH'(validQ.size()), 32'd1);
        if (validQ.size() > 0) checkOutput("ign_vcyc", WIDTH'(validQ[0] - base), 32'd33);

        // Reset at cycle 15 of RUN aborts the operation.
        $display("[TB] reset in run");
        validQ.delete();
        applyStimulus(32'd9, 32'd9, 5'd7, 1'b0);
        for (int c = 0; c <= 40; c++) begin
            if (c == 15) RESET = 1'b1;
            if (c == 16) RESET = 1'b0;
            stepCycle(s, bz, r, rr);
            if (c == 0) i_start = 1'b0;
            if (c == 16) begin
                checkOutput("rrun_stall", WIDTH'(s), 32'd0);
                checkOutput("rrun_busy", WIDTH'(bz), 32'd0);
                checkOutput("rrun_result", r, 32'd0);
                checkOutput("rrun_result_reg", WIDTH'(rr), 32'd0);
            end
        end
        checkOutput("rrun_novalid", WIDTH'(validQ.size()), 32'd0);
        checkOutput("scoreboard_empty", WIDTH'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
